seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for the 4-digit common-anode 7-segment display.
//  Shares one hex segment decoder across digits 3..0. Enables one anode at a time,
//    with a blanking gap between digits to suppress ghosting.
//  Accepts a new 16-bit value through a valid/ready handshake. The value is committed
//    only at a frame boundary, so one frame never mixes old and new digits.
//  Sits between the adder/ALU datapath (source of value and overflow) and the board pins.
// PARAMETERS
//  DIGIT_CYCLES  100000  clk cycles each digit is lit (must be >= 1)
//  GAP_CYCLES    1000    clk cycles all anodes are off between digits (0 = no gap)
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  upd_valid  in   1   update request
//  upd_ready  out  1   controller can accept an update this cycle
//  upd_data   in   16  hex value; digit i = upd_data[4i+3:4i]
//  upd_blank  in   4   1 = digit i stays dark
//  upd_dp     in   4   1 = decimal point of digit i lit (e.g. overflow flag)
//  AN         out  4   anode enables, active-low
//  SEG        out  7   segments {g,f,e,d,c,b,a}, active-low
//  DP         out  1   decimal point, active-low
//  frame_done out  1   1-cycle pulse at the end of digit 3's SHOW phase
// BEHAVIOUR
//  Reset (async, immediate, also mid-frame):
//   - AN=4'b1111, SEG=7'h7F, DP=1, frame_done=0.
//   - State=GAP, idx=0, cnt=0.
//   - Active value/blank/dp = 0.
//   - Pending slot empty, so upd_ready=1 from the first cycle after reset deasserts.
//  State machine, states GAP and SHOW; cnt is cleared on every transition:
//   - GAP: AN=1111, SEG=7F, DP=1. Stay while cnt < GAP_CYCLES-1.
//   - GAP -> SHOW: taken at cnt==GAP_CYCLES-1, or immediately when GAP_CYCLES==0.
//   - SHOW: AN[idx]=0 (others 1) unless blank[idx]=1, in which case AN=1111.
//   - SHOW: SEG=hex7seg(active[idx]); DP=~dp[idx].
//   - SHOW -> GAP: at cnt==DIGIT_CYCLES-1; idx <= idx+1 mod 4 (3 wraps to 0).
//  Digit order is 0,1,2,3. Frame length = 4*(DIGIT_CYCLES+GAP_CYCLES) cycles.
//  Decode table (active-low {g..a}), hex digits 0..F:
//   - 0-7: 40,79,24,30,19,12,02,78
//   - 8-F: 00,10,08,03,46,21,06,0E
//  Outputs AN/SEG/DP are flopped: they take the new state's value on the same edge
//    that enters that state. There is no combinational path from inputs to outputs.
//  Handshake:
//   - upd_ready = ~pend_valid, decoded from a register.
//   - A transfer occurs on an edge where upd_valid && upd_ready.
//   - On a transfer, upd_data/blank/dp are captured into pending and pend_valid <= 1.
//   - While pend_valid=1, upd_ready=0 and upd_valid is ignored; the upstream holds its data.
//  Commit: on the GAP->SHOW edge with idx==0, if pend_valid:
//   - active <= pending and pend_valid <= 0.
//   - Digit 0 of that frame already shows the new value.
//   - upd_ready returns to 1 on the next cycle.
//   - A request held across the commit edge transfers on the first cycle ready=1.
//  frame_done pulses on the SHOW->GAP edge with idx==3, simultaneous with the idx wrap.
//  No update pending at frame start: the active value is redisplayed unchanged.
//  cnt width = $clog2(max(DIGIT_CYCLES,GAP_CYCLES,2)). No other counter may overflow.
// TESTING (DIGIT_CYCLES=4, GAP_CYCLES=1 unless noted; frame = 20 cycles)
//  T1 Reset mid-SHOW
//   - Stimulus: assert reset between clock edges.
//   - Required: AN=1111, SEG=7F, DP=1 before the next edge.
//   - After release: first SHOW is idx 0 with value 0, i.e. AN=1110, SEG=40.
//  T2 Scan timing
//   - Stimulus: load 16'h1234, blank=0, dp=0.
//   - Required: SEG 24,30,19,79... wait for active-low order digit0=4 -> 19, digit1=3 -> 30,
//     digit2=2 -> 24, digit3=1 -> 79.
//   - Required: AN sequence 1110,1101,1011,0111; each lit exactly 4 cycles.
//   - Required: 1 cycle of 1111 between digits; frame_done every 20 cycles.
//  T3 Frame-coherent update
//   - Stimulus: while digit 2 of 16'h1234 is lit, send 16'hABCD.
//   - Required: digit 3 still shows 1 (79).
//   - Required: next frame shows D,C,B,A (21,46,03,08).
//   - Required: upd_ready=0 from transfer until one cycle after the commit.
//  T4 Back-pressure
//   - Stimulus: hold upd_valid with 16'h0F0F, then 16'hFFFF, back-to-back.
//   - Required: the second transfer occurs only after the first commit.
//   - Required: no value is lost or skipped; frames show 0F0F, then FFFF.
//  T5 Blank and DP
//   - Stimulus: blank=4'b1010, dp=4'b0001.
//   - Required: AN stays 1111 during digit 1/3 slots.
//   - Required: DP=0 only during digit 0's SHOW phase.
//  T6 GAP_CYCLES=0, DIGIT_CYCLES=1
//   - Required: AN rotates 1110,1101,1011,0111 every cycle.
//   - Required: frame_done every 4 cycles.
```

Correction to T2, which reads awkwardly as written: required SEG sequence for 16'h1234 is digit0=19, digit1=30, digit2=24, digit3=79.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Purpose : time-multiplexed scan controller for a 4-digit common-anode 7-segment
//           display; one shared hex decoder, blanking gap between digits, and
//           frame-coherent value updates through a valid/ready handshake.
// Latency : outputs are registered; a committed value appears on digit 0 of the
//           frame that starts on the commit edge.
// Backpressure: one pending slot; upd_ready drops after a transfer and returns the
//           cycle after the pending value is committed at the next frame start.
// Ports   : clk/reset (async, active-high); upd_valid/upd_ready/upd_data/upd_blank/
//           upd_dp update channel; AN/SEG/DP active-low pins; frame_done pulse.
module seg7_scan_ctrl #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int GAP_CYCLES   = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [15:0] upd_data,
  input  logic [3:0]  upd_blank,
  input  logic [3:0]  upd_dp,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        frame_done
);

  localparam int MAX_DG  = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (MAX_DG > 2) ? MAX_DG : 2;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] DIG_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic {ST_GAP, ST_SHOW} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   active_q, active_d;
  logic [3:0]    blank_q, blank_d;
  logic [3:0]    dpsel_q, dpsel_d;
  logic          pend_valid_q, pend_valid_d;
  logic [15:0]   pend_data_q, pend_data_d;
  logic [3:0]    pend_blank_q, pend_blank_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;
  logic          enter_show;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex7seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign upd_ready  = ~pend_valid_q;
  assign AN         = an_q;
  assign SEG        = seg_q;
  assign DP         = dp_q;
  assign frame_done = frame_done_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    idx_d        = idx_q;
    active_d     = active_q;
    blank_d      = blank_q;
    dpsel_d      = dpsel_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_blank_d = pend_blank_q;
    pend_dp_d    = pend_dp_q;
    frame_done_d = 1'b0;
    enter_show   = 1'b0;
    an_d         = 4'hF;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;

    case (state_q)
      ST_GAP: begin
        if (GAP_CYCLES == 0 || cnt_q == GAP_LAST) begin
          state_d    = ST_SHOW;
          cnt_d      = '0;
          enter_show = 1'b1;
        end
      end
      default: begin
        if (cnt_q == DIG_LAST) begin
          idx_d        = idx_q + 2'd1;
          cnt_d        = '0;
          frame_done_d = (idx_q == 2'd3);
          // With no gap configured the next digit is entered directly.
          if (GAP_CYCLES == 0) begin
            state_d    = ST_SHOW;
            enter_show = 1'b1;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
    endcase

    // Frame start: swap in the pending value so digit 0 already shows it.
    if (enter_show && idx_d == 2'd0 && pend_valid_q) begin
      active_d     = pend_data_q;
      blank_d      = pend_blank_q;
      dpsel_d      = pend_dp_q;
      pend_valid_d = 1'b0;
    end

    // A commit needs pend_valid=1 and a transfer needs it 0, so they never collide.
    if (upd_valid && !pend_valid_q) begin
      pend_data_d  = upd_data;
      pend_blank_d = upd_blank;
      pend_dp_d    = upd_dp;
      pend_valid_d = 1'b1;
    end

    // Outputs are precomputed from the state being entered so they are flopped.
    if (state_d == ST_SHOW) begin
      an_d  = blank_d[idx_d] ? 4'hF : ~(4'b0001 << idx_d);
      seg_d = hex7seg(active_d[{idx_d, 2'b00} +: 4]);
      dp_d  = ~dpsel_d[idx_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_GAP;
      cnt_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      blank_q      <= '0;
      dpsel_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_blank_q <= '0;
      pend_dp_q    <= '0;
      an_q         <= 4'hF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      blank_q      <= blank_d;
      dpsel_q      <= dpsel_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_blank_q <= pend_blank_d;
      pend_dp_q    <= pend_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: instance A (DIGIT_CYCLES=4, GAP_CYCLES=1) against a
// cycle-position reference model; instance B (DIGIT_CYCLES=1, GAP_CYCLES=0).
module tb_seg7_scan_ctrl;

  localparam int DA = 4, GA = 1, SA = DA + GA, FA = 4 * SA, LEAD_A = 1;
  localparam int FD_POS = 3 * SA + DA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, v_a = 1'b0, rdy_a, dp_a, fd_a;
  logic [15:0] d_a = '0;
  logic [3:0]  b_a = '0, p_a = '0, an_a;
  logic [6:0]  seg_a;

  logic        rst_b = 1'b1, v_b = 1'b0, rdy_b, dp_b, fd_b;
  logic [15:0] d_b = '0;
  logic [3:0]  b_b = '0, p_b = '0, an_b;
  logic [6:0]  seg_b;

  seg7_scan_ctrl #(.DIGIT_CYCLES(DA), .GAP_CYCLES(GA)) dut_a (
    .clk(clk), .reset(rst_a), .upd_valid(v_a), .upd_ready(rdy_a), .upd_data(d_a),
    .upd_blank(b_a), .upd_dp(p_a), .AN(an_a), .SEG(seg_a), .DP(dp_a), .frame_done(fd_a));

  seg7_scan_ctrl #(.DIGIT_CYCLES(1), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset(rst_b), .upd_valid(v_b), .upd_ready(rdy_b), .upd_data(d_b),
    .upd_blank(b_b), .upd_dp(p_b), .AN(an_b), .SEG(seg_b), .DP(dp_b), .frame_done(fd_b));

  int total = 0, bad = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: k counts cycles since reset release; the display position
  // follows from k by plain arithmetic.
  int          k;
  logic [15:0] m_act, m_pdat;
  logic [3:0]  m_blk, m_dpv, m_pblk, m_pdp;
  bit          m_pend, last_xfer, exp_show;
  int          exp_digit;
  logic [13:0] exp_vec;  // {AN, SEG, DP, frame_done, upd_ready}

  task automatic compute_exp();
    int pos;
    logic [3:0] an;
    logic [6:0] seg;
    logic dp, fd;
    pos = k - LEAD_A;
    an = 4'hF; seg = 7'h7F; dp = 1'b1;
    exp_show = 0; exp_digit = 0;
    if (pos >= 0 && (pos % SA) < DA) begin
      exp_show  = 1;
      exp_digit = (pos / SA) % 4;
      an  = m_blk[exp_digit] ? 4'hF : ~(4'b0001 << exp_digit);
      seg = seg_tab[m_act[exp_digit*4 +: 4]];
      dp  = ~m_dpv[exp_digit];
    end
    fd = (pos >= FD_POS) && (((pos - FD_POS) % FA) == 0);
    exp_vec = {an, seg, dp, fd, ~m_pend};
  endtask

  task automatic model_clear();
    k = 0; m_act = '0; m_blk = '0; m_dpv = '0;
    m_pdat = '0; m_pblk = '0; m_pdp = '0; m_pend = 0; last_xfer = 0;
    compute_exp();
  endtask

  // Drive inputs for the next edge, advance the model across it, land on the negedge.
  task automatic step(input bit v, input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    int pos_n;
    v_a = v; d_a = d; b_a = b; p_a = p;
    pos_n = k + 1 - LEAD_A;
    last_xfer = 0;
    if (pos_n >= 0 && (pos_n % FA) == 0 && m_pend) begin
      m_act = m_pdat; m_blk = m_pblk; m_dpv = m_pdp; m_pend = 0;
    end else if (v && !m_pend) begin
      m_pdat = d; m_pblk = b; m_pdp = p; m_pend = 1; last_xfer = 1;
    end
    @(negedge clk);
    k++;
    compute_exp();
  endtask

  task automatic do_reset();
    rst_a = 1'b1; v_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    n = 0;
    step(1'b1, 16'h1234, 4'h0, 4'h0);
    // Run into digit 2 of a frame showing 1234, then hit reset mid-SHOW.
    while (!(exp_show && exp_digit == 2 && m_act == 16'h1234) && n < 60) begin
      total++;
      if ({an_a, seg_a, dp_a, fd_a, rdy_a} !== exp_vec) begin
        bad++; $display("FAIL reset_pre k=%0d got=%h exp=%h", k, {an_a, seg_a, dp_a, fd_a, rdy_a}, exp_vec);
      end
      step(1'b0, 16'h0, 4'h0, 4'h0);
      n++;
    end
    total++;
    if (an_a !== 4'b1011) begin
      bad++; $display("FAIL reset_show_reached got=%b exp=1011", an_a);
    end
    #2 rst_a = 1'b1;
    #1;
    total++;
    if ({an_a, seg_a, dp_a, fd_a, rdy_a} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL reset_async got=%h exp=%h", {an_a, seg_a, dp_a, fd_a, rdy_a}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1});
    end
    @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    model_clear();
    total++;
    if ({an_a, seg_a, dp_a, fd_a, rdy_a} !== exp_vec) begin
      bad++; $display("FAIL reset_gap got=%h exp=%h", {an_a, seg_a, dp_a, fd_a, rdy_a}, exp_vec);
    end
    step(1'b0, 16'h0, 4'h0, 4'h0);
    total++;
    if ({an_a, seg_a} !== {4'b1110, 7'h40}) begin
      bad++; $display("FAIL reset_first_show got=%h exp=%h", {an_a, seg_a}, {4'b1110, 7'h40});
    end
  endtask

  task automatic test_scan();
    int last_fd;
    do_reset();
    last_fd = -1;
    step(1'b1, 16'h1234, 4'h0, 4'h0);
    for (int i = 0; i < 2 * FA + 4; i++) begin
      total++;
      if ({an_a, seg_a, dp_a, fd_a, rdy_a} !== exp_vec) begin
        bad++; $display("FAIL scan k=%0d got=%h exp=%h", k, {an_a, seg_a, dp_a, fd_a, rdy_a}, exp_vec);
      end
      if (fd_a === 1'b1) begin
        if (last_fd >= 0) begin
          total++;
          if (k - last_fd != FA) begin
            bad++; $display("FAIL scan_frame_period got=%0d exp=%0d", k - last_fd, FA);
          end
        end
        last_fd = k;
      end
      step(1'b0, 16'h0, 4'h0, 4'h0);
    end
  endtask

  task automatic test_update();
    int n;
    bit sent;
    n = 0;
    while (!(exp_show && exp_digit == 2) && n < 40) begin
      step(1'b0, 16'h0, 4'h0, 4'h0);
      n++;
    end
    sent = 0;
    for (int i = 0; i < 2 * FA + 4; i++) begin
      total++;
      if ({an_a, seg_a, dp_a, fd_a, rdy_a} !== exp_vec) begin
        bad++; $display("FAIL update k=%0d got=%h exp=%h", k, {an_a, seg_a, dp_a, fd_a, rdy_a}, exp_vec);
      end
      if (sent && exp_show && exp_digit == 3 && m_act == 16'h1234) begin
        total++;
        if (seg_a !== 7'h79) begin
          bad++; $display("FAIL update_old_digit3 got=%h exp=79", seg_a);
        end
      end
      if (exp_show && exp_digit == 0 && m_act == 16'hABCD) begin
        total++;
        if (seg_a !== 7'h21) begin
          bad++; $display("FAIL update_new_digit0 got=%h exp=21", seg_a);
        end
      end
      step(!sent, 16'hABCD, 4'h0, 4'h0);
      if (last_xfer) sent = 1;
    end
  endtask

  task automatic test_back_to_back();
    int phase;
    logic [15:0] val;
    phase = 0;
    for (int i = 0; i < 4 * FA; i++) begin
      total++;
      if ({an_a, seg_a, dp_a, fd_a, rdy_a} !== exp_vec) begin
        bad++; $display("FAIL back_to_back k=%0d got=%h exp=%h", k, {an_a, seg_a, dp_a, fd_a, rdy_a}, exp_vec);
      end
      val = (phase == 0) ? 16'h0F0F : 16'hFFFF;
      step(phase < 2, val, 4'h0, 4'h0);
      if (last_xfer) phase++;
    end
    total++;
    if (phase != 2) begin
      bad++; $display("FAIL back_to_back_transfers got=%0d exp=2", phase);
    end
  endtask

  task automatic test_blank_dp();
    bit sent;
    sent = 0;
    for (int i = 0; i < 3 * FA; i++) begin
      total++;
      if ({an_a, seg_a, dp_a, fd_a, rdy_a} !== exp_vec) begin
        bad++; $display("FAIL blank_dp k=%0d got=%h exp=%h", k, {an_a, seg_a, dp_a, fd_a, rdy_a}, exp_vec);
      end
      step(!sent, 16'h5678, 4'b1010, 4'b0001);
      if (last_xfer) sent = 1;
    end
  endtask

  task automatic test_random();
    bit          req;
    logic [15:0] rd;
    logic [3:0]  rb, rp;
    req = 0; rd = '0; rb = '0; rp = '0;
    for (int i = 0; i < 600; i++) begin
      total++;
      if ({an_a, seg_a, dp_a, fd_a, rdy_a} !== exp_vec) begin
        bad++; $display("FAIL random k=%0d got=%h exp=%h", k, {an_a, seg_a, dp_a, fd_a, rdy_a}, exp_vec);
      end
      if (!req && $urandom_range(0, 7) == 0) begin
        req = 1;
        rd = 16'($urandom); rb = 4'($urandom); rp = 4'($urandom);
      end
      step(req, rd, rb, rp);
      if (last_xfer) req = 0;
    end
  endtask

  task automatic test_no_gap();
    int pos;
    logic [3:0] ean;
    logic [6:0] eseg;
    logic efd;
    rst_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    for (int kb = 0; kb < 22; kb++) begin
      pos  = kb - 1;
      ean  = (pos < 0) ? 4'hF : ~(4'b0001 << (pos % 4));
      eseg = (pos < 0) ? 7'h7F : 7'h40;
      efd  = (pos >= 4) && ((pos % 4) == 0);
      total++;
      if ({an_b, seg_b, fd_b} !== {ean, eseg, efd}) begin
        bad++; $display("FAIL no_gap k=%0d got=%h exp=%h", kb, {an_b, seg_b, fd_b}, {ean, eseg, efd});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_scan();
    test_update();
    test_back_to_back();
    test_blank_dp();
    test_random();
    test_no_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
